// File: rtl/sha256_block_feeder.sv
// sha256_block_feeder: word-serial front end for the SHA-256 core.
// Collects 16 host words per block, applies SHA-256 padding and the 64-bit
// bit-length on the message's last word, and hands 512-bit blocks to the core.
// Optional build macro: SHA256_FEEDER_BSWAP_EN byte-reverses each incoming
// host word before it is stored (padding and length words are never swapped).
module sha256_block_feeder #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  input  logic               in_last,
  output logic [31:0]        block_data [16],
  output logic               block_valid,
  input  logic               block_ready,
  output logic               block_first,
  output logic               block_final,
  output logic               busy
);

  typedef enum logic {FILL, SEND} state_t;

  state_t             state;
  logic [3:0]         idx;
  logic [COUNT_W-1:0] count;
  logic               tail_pend;
  logic               tail_mark;

  logic [31:0]        word_in;
  logic [COUNT_W-1:0] count_inc;
  logic [63:0]        len_cur;   // length including the word being accepted
  logic [63:0]        len_tot;   // length of all words already accepted
  logic               accept;

`ifdef SHA256_FEEDER_BSWAP_EN
  assign word_in = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};
`else
  assign word_in = in_data;
`endif

  assign count_inc = count + 1'b1;
  assign len_cur   = 64'(count_inc) << 5;
  assign len_tot   = 64'(count) << 5;

  // The buffer doubles as the block output, so it is only writable in FILL.
  assign in_ready  = (state == FILL) && !reset;
  assign accept    = in_valid && in_ready;

  // Feeder FSM: buffer fill, in-cycle padding, block handoff and tail block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FILL;
      idx         <= '0;
      count       <= '0;
      tail_pend   <= 1'b0;
      tail_mark   <= 1'b0;
      block_valid <= 1'b0;
      block_first <= 1'b1;
      block_final <= 1'b0;
      busy        <= 1'b0;
      for (int j = 0; j < 16; j++) block_data[j] <= '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            block_data[idx] <= word_in;
            idx             <= idx + 4'd1;
            count           <= count_inc;
            busy            <= 1'b1;
            if (in_last) begin
              state       <= SEND;
              block_valid <= 1'b1;
              if (idx <= 4'd12) begin
                // Pad marker, zeros and length all fit in this block.
                for (int j = 0; j < 14; j++)
                  if (j > int'(idx))
                    block_data[j] <= (j == int'(idx) + 1) ? 32'h8000_0000 : 32'h0;
                block_data[14] <= len_cur[63:32];
                block_data[15] <= len_cur[31:0];
                block_final    <= 1'b1;
              end else begin
                // Length no longer fits: marker here if room, rest in a tail block.
                if (idx == 4'd13) begin
                  block_data[14] <= 32'h8000_0000;
                  block_data[15] <= 32'h0;
                end else if (idx == 4'd14) begin
                  block_data[15] <= 32'h8000_0000;
                end
                tail_pend   <= 1'b1;
                tail_mark   <= (idx == 4'd15);
                block_final <= 1'b0;
              end
            end else if (idx == 4'd15) begin
              state       <= SEND;
              block_valid <= 1'b1;
              block_final <= 1'b0;
            end
          end
        end
        SEND: begin
          if (block_ready) begin
            if (tail_pend) begin
              // Tail block follows directly; count already holds the full length.
              block_data[0] <= tail_mark ? 32'h8000_0000 : 32'h0;
              for (int j = 1; j < 14; j++) block_data[j] <= 32'h0;
              block_data[14] <= len_tot[63:32];
              block_data[15] <= len_tot[31:0];
              block_final    <= 1'b1;
              block_first    <= 1'b0;
              tail_pend      <= 1'b0;
            end else if (block_final) begin
              state       <= FILL;
              block_valid <= 1'b0;
              block_final <= 1'b0;
              block_first <= 1'b1;
              count       <= '0;
              idx         <= '0;
              busy        <= 1'b0;
            end else begin
              state       <= FILL;
              block_valid <= 1'b0;
              block_first <= 1'b0;
              idx         <= '0;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block_feeder.sv
// Bench for sha256_block_feeder: table of messages checked through a block
// scoreboard, plus hand sequences for reset, backpressure and mid-message reset.
module tb_sha256_block_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [31:0] block_data [16];
  logic        block_valid;
  logic        block_ready;
  logic        block_first;
  logic        block_final;
  logic        busy;

  sha256_block_feeder #(.COUNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .block_data(block_data), .block_valid(block_valid), .block_ready(block_ready),
    .block_first(block_first), .block_final(block_final), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w [16];
    logic        first;
    logic        fin;
  } blk_t;

  typedef struct {
    int          nwords;
    logic [31:0] seed;
    int          exp_nblk;
    logic [31:0] exp_w15;   // last word of the final block
    logic [31:0] exp_w0;    // first word of the first block
  } vec_t;

  blk_t        q [$];
  int          compared = 0;
  int          mism = 0;
  int          hs_count = 0;
  logic [31:0] seen_w0, seen_w15;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] sw(input logic [31:0] d);
`ifdef SHA256_FEEDER_BSWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  // Reference padding: whole message laid out flat, then cut into blocks.
  task automatic push_expected(input int n, input logic [31:0] seed);
    logic [31:0] m [64];
    logic [63:0] len;
    int nblk;
    blk_t b;
    nblk = (n + 18) / 16;
    for (int i = 0; i < 64; i++) m[i] = 32'h0;
    for (int i = 0; i < n; i++) m[i] = sw(seed + 32'(i));
    m[n] = 32'h8000_0000;
    len = 64'(n) * 64'd32;
    m[nblk*16-2] = len[63:32];
    m[nblk*16-1] = len[31:0];
    for (int k = 0; k < nblk; k++) begin
      for (int i = 0; i < 16; i++) b.w[i] = m[k*16+i];
      b.first = (k == 0);
      b.fin   = (k == nblk - 1);
      q.push_back(b);
    end
  endtask

  // Drive n words (seed+i) on the stream, honouring in_ready with a bound.
  task automatic send_words(input int n, input logic [31:0] seed, input logic last_on_end);
    int guard;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = seed + 32'(i);
      in_last  = last_on_end && (i == n - 1);
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 200) begin
        guard++;
        @(negedge clk);
      end
      if (guard >= 200) chk("in_ready_timeout", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() != 0 && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every handshake pops and checks one expected block.
  initial begin
    blk_t e;
    int bad;
    forever begin
      @(negedge clk);
      if (!reset && block_valid && block_ready) begin
        hs_count++;
        if (hs_count == 1) seen_w0 = block_data[0];
        if (block_final) seen_w15 = block_data[15];
        if (q.size() == 0) begin
          compared++; mism++;
          $display("FAIL unexpected_block: got handshake want none (w0=%0h)", block_data[0]);
        end else begin
          e = q.pop_front();
          bad = -1;
          for (int i = 0; i < 16; i++)
            if (bad < 0 && block_data[i] !== e.w[i]) bad = i;
          compared++;
          if (bad >= 0) begin
            mism++;
            $display("FAIL blk_data[%0d]: got %0h want %0h", bad, block_data[bad], e.w[bad]);
          end
          chk("blk_first", 64'(block_first), 64'(e.first));
          chk("blk_final", 64'(block_final), 64'(e.fin));
          chk("busy_during_blk", 64'(busy), 64'd1);
          if (e.fin) begin
            @(negedge clk);
            chk("busy_fall", 64'(busy), 64'd0);
            chk("valid_fall", 64'(block_valid), 64'd0);
          end
        end
      end
    end
  end

  vec_t vecs [8];
  logic [31:0] snap;

  initial begin
    vecs[0] = '{1,  32'h6162_6364, 1, 32'h20,  sw(32'h6162_6364)};
    vecs[1] = '{14, 32'h0,         2, 32'h1C0, sw(32'h0)};
    vecs[2] = '{16, 32'h100,       2, 32'h200, sw(32'h100)};
    vecs[3] = '{20, 32'hA000_0000, 2, 32'h280, sw(32'hA000_0000)};
    vecs[4] = '{13, 32'h55,        1, 32'h1A0, sw(32'h55)};
    vecs[5] = '{15, 32'h0,         2, 32'h1E0, sw(32'h0)};
`ifdef SHA256_FEEDER_BSWAP_EN
    vecs[6] = '{1,  32'h0102_0304, 1, 32'h20,  32'h0403_0201};
`else
    vecs[6] = '{1,  32'h0102_0304, 1, 32'h20,  32'h0102_0304};
`endif
    vecs[7] = '{32, 32'h7,         3, 32'h400, sw(32'h7)};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; block_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_valid", 64'(block_valid), 64'd0);
    chk("rst_first", 64'(block_first), 64'd1);
    chk("rst_final", 64'(block_final), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_data0", 64'(block_data[0]), 64'd0);
    chk("rst_data15", 64'(block_data[15]), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Table of messages
    for (int r = 0; r < 8; r++) begin
      hs_count = 0;
      push_expected(vecs[r].nwords, vecs[r].seed);
      send_words(vecs[r].nwords, vecs[r].seed, 1'b1);
      drain();
      chk($sformatf("v%0d_nblk", r), 64'(hs_count), 64'(vecs[r].exp_nblk));
      chk($sformatf("v%0d_w0", r), 64'(seen_w0), 64'(vecs[r].exp_w0));
      chk($sformatf("v%0d_w15", r), 64'(seen_w15), 64'(vecs[r].exp_w15));
    end

    // Backpressure: block held 5 cycles while a stray word waits on the stream
    hs_count = 0;
    block_ready = 1'b0;
    push_expected(1, 32'hCAFE_0001);
    send_words(1, 32'hCAFE_0001, 1'b1);
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_last = 1'b1;
    @(negedge clk);
    snap = block_data[0];
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_valid", 64'(block_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_stable", 64'(block_data[0]), 64'(snap));
    end
    @(posedge clk); #1;
    block_ready = 1'b1;
    in_valid = 1'b0; in_last = 1'b0;
    drain();
    chk("bp_one_hs", 64'(hs_count), 64'd1);
    chk("bp_stray_not_taken", 64'(busy), 64'd0);
    chk("bp_snap_word", 64'(snap), 64'(sw(32'hCAFE_0001)));

    // Reset after 7 words discards them
    hs_count = 0;
    send_words(7, 32'h7700, 1'b0);
    @(negedge clk);
    chk("mid_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    push_expected(1, 32'h1111_1111);
    send_words(1, 32'h1111_1111, 1'b1);
    drain();
    chk("mid_nblk", 64'(hs_count), 64'd1);
    chk("mid_w0", 64'(seen_w0), 64'h1111_1111);
    chk("mid_w15", 64'(seen_w15), 64'h20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
